// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and constants for the round-robin lock arbiter
package rr_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   localparam int NREQ_DEF = 4;
   localparam int GID_W    = 2;

endpackage

// File: rtl/rr_lock_arbiter_if.sv
// rtl/rr_lock_arbiter_if.sv - request/grant bundle between requesters and the arbiter
interface rr_lock_arbiter_if import rr_arb_pkg::*; #(
   parameter int NREQ = NREQ_DEF
);
   logic             stall;
   logic [NREQ-1:0]  req;
   logic             done;
   logic [NREQ-1:0]  grant;
   logic             grant_valid;
   logic [GID_W-1:0] grant_id;
   logic             timeout_err;

   modport master (
      output stall, req, done,
      input  grant, grant_valid, grant_id, timeout_err
   );

   modport slave (
      input  stall, req, done,
      output grant, grant_valid, grant_id, timeout_err
   );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotate-priority encoder: first set request at or above ptr, wrapping
module rr_pick import rr_arb_pkg::*; (
   input  logic [NREQ_DEF-1:0] req,
   input  logic [GID_W-1:0]    ptr,
   output logic [NREQ_DEF-1:0] winner,
   output logic [GID_W-1:0]    idx
);

   always_comb begin
      logic             found;
      logic [GID_W-1:0] cand;
      winner = '0;
      idx    = '0;
      found  = 1'b0;
      cand   = ptr;
      for (int i = 0; i < NREQ_DEF; i++) begin
         // GID_W-bit addition wraps 3 -> 0 on its own
         cand = ptr + GID_W'(i);
         if (!found && req[cand]) begin
            found       = 1'b1;
            winner[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/rr_lock_arbiter.sv
// rtl/rr_lock_arbiter.sv - locking round-robin arbiter; optional watchdog via ARB_TIMEOUT_EN
module rr_lock_arbiter import rr_arb_pkg::*; #(
   parameter int NREQ    = NREQ_DEF,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   rr_lock_arbiter_if.slave arb
);

   if (NREQ != NREQ_DEF || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
      $error("rr_lock_arbiter: NREQ must be 4 and TIMEOUT in 2..255");
   end

   arb_state_e       state_q, state_d;
   logic [NREQ-1:0]  grant_q, grant_d;
   logic [GID_W-1:0] grant_id_q, grant_id_d;
   logic [GID_W-1:0] ptr_q, ptr_d;
   logic [NREQ-1:0]  pick_winner;
   logic [GID_W-1:0] pick_idx;
   logic             timeout_hit;

   rr_pick u_pick (
      .req    (arb.req),
      .ptr    (ptr_q),
      .winner (pick_winner),
      .idx    (pick_idx)
   );

`ifdef ARB_TIMEOUT_EN
   logic [7:0] timer_q, timer_d;
   logic       timeout_err_q;

   assign timeout_hit = (state_q == BUSY) && !arb.stall && !arb.done &&
                        (timer_q == 8'(TIMEOUT - 1));

   always_comb begin
      timer_d = timer_q;
      if (!arb.stall) begin
         if (state_q == IDLE && state_d == BUSY) begin
            timer_d = '0;
         end else if (state_q == BUSY && !arb.done) begin
            timer_d = timer_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         timer_q       <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         timer_q       <= timer_d;
         timeout_err_q <= timeout_hit;
      end
   end

   assign arb.timeout_err = timeout_err_q;
`else
   assign timeout_hit     = 1'b0;
   assign arb.timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         ptr_q      <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         ptr_q      <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!arb.stall) begin
         case (state_q)
            IDLE:    if (|arb.req) state_d = BUSY;
            BUSY:    if (arb.done || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // ptr only advances on release, so a holder keeps priority order stable
   always_comb begin
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      ptr_d      = ptr_q;
      if (!arb.stall) begin
         if (state_q == IDLE && |arb.req) begin
            grant_d    = pick_winner;
            grant_id_d = pick_idx;
         end else if (state_q == BUSY && (arb.done || timeout_hit)) begin
            grant_d = '0;
            ptr_d   = grant_id_q + GID_W'(1);
         end
      end
   end

   assign arb.grant       = grant_q;
   assign arb.grant_valid = |grant_q;
   assign arb.grant_id    = grant_id_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb/tb_rr_lock_arbiter.sv - directed self-checking bench for rr_lock_arbiter
module tb_rr_lock_arbiter;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   rr_lock_arbiter_if arb_if ();

   rr_lock_arbiter #(.NREQ(4), .TIMEOUT(15)) dut (
      .clk   (clk),
      .reset (reset),
      .arb   (arb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // inputs change and outputs are sampled on the falling edge
   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [3:0] rr_exp [5];
      logic [1:0] rr_id  [5];
      int         hold;
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rr_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      n_tests = 0;
      n_fail  = 0;
      reset        = 1'b0;
      arb_if.stall = 1'b0;
      arb_if.req   = 4'b0000;
      arb_if.done  = 1'b0;
      tick(2);
      check("rst_grant", arb_if.grant, 4'b0000);
      check("rst_gv", arb_if.grant_valid, 1'b0);
      check("rst_gid", arb_if.grant_id, 2'd0);
      check("rst_terr", arb_if.timeout_err, 1'b0);
      reset = 1'b1;

      // req=0101, done on 3rd BUSY cycle
      arb_if.req = 4'b0101;
      tick();
      check("r26_c1", arb_if.grant, 4'b0001);
      check("r26_gv", arb_if.grant_valid, 1'b1);
      tick();
      check("r26_c2", arb_if.grant, 4'b0001);
      tick();
      check("r26_c3", arb_if.grant, 4'b0001);
      arb_if.done = 1'b1;
      tick();
      check("r26_gap", arb_if.grant, 4'b0000);
      check("r26_gap_gv", arb_if.grant_valid, 1'b0);
      arb_if.done = 1'b0;
      tick();
      check("r26_next", arb_if.grant, 4'b0100);
      check("r26_next_id", arb_if.grant_id, 2'd2);
      arb_if.done = 1'b1;
      arb_if.req  = 4'b0000;
      tick();
      check("r26_rel", arb_if.grant, 4'b0000);
      check("gid_hold", arb_if.grant_id, 2'd2);
      // done in IDLE is ignored; ptr=3 so 1001 picks bit 3
      arb_if.req = 4'b1001;
      tick();
      check("idle_done", arb_if.grant, 4'b1000);
      tick();
      check("idle_done_rel", arb_if.grant, 4'b0000);

      // full rotation from a fresh pointer
      reset = 1'b0;
      tick();
      reset       = 1'b1;
      arb_if.req  = 4'b1111;
      arb_if.done = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("rr_grant%0d", k), arb_if.grant, rr_exp[k]);
         check($sformatf("rr_id%0d", k), arb_if.grant_id, rr_id[k]);
         tick();
         check($sformatf("rr_gap%0d", k), arb_if.grant, 4'b0000);
      end
      arb_if.done = 1'b0;
      arb_if.req  = 4'b0000;

      // stall with done held, ptr=1
      arb_if.req = 4'b0010;
      tick();
      check("st_grant", arb_if.grant, 4'b0010);
      arb_if.stall = 1'b1;
      arb_if.done  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("st_hold%0d", k), arb_if.grant, 4'b0010);
      end
      arb_if.stall = 1'b0;
      tick();
      check("st_rel", arb_if.grant, 4'b0000);
      arb_if.done  = 1'b0;
      arb_if.stall = 1'b1;
      arb_if.req   = 4'b1111;
      tick();
      check("st_idle", arb_if.grant, 4'b0000);
      arb_if.stall = 1'b0;
      tick();
      check("st_ptr2", arb_if.grant, 4'b0100);
      arb_if.done = 1'b1;
      arb_if.req  = 4'b0000;
      tick();
      check("st_ptr2_rel", arb_if.grant, 4'b0000);
      arb_if.done = 1'b0;

      // holder drops req mid-BUSY, ptr=3
      arb_if.req = 4'b1000;
      tick();
      check("drop_grant", arb_if.grant, 4'b1000);
      arb_if.req = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("drop_hold%0d", k), arb_if.grant, 4'b1000);
      end

      // reset mid-transaction overrides stall
      reset        = 1'b0;
      arb_if.stall = 1'b1;
      tick();
      check("mrst_grant", arb_if.grant, 4'b0000);
      check("mrst_gid", arb_if.grant_id, 2'd0);
      check("mrst_gv", arb_if.grant_valid, 1'b0);
      reset        = 1'b1;
      arb_if.stall = 1'b0;
      arb_if.req   = 4'b1111;
      tick();
      check("mrst_first", arb_if.grant, 4'b0001);
      arb_if.done = 1'b1;
      arb_if.req  = 4'b0000;
      tick();
      check("mrst_rel", arb_if.grant, 4'b0000);
      arb_if.done = 1'b0;

      // no done: watchdog release or indefinite hold, ptr=1
`ifdef ARB_TIMEOUT_EN
      hold = 15;
`else
      hold = 100;
`endif
      arb_if.req = 4'b0010;
      tick();
      for (int c = 0; c < hold; c++) begin
         check($sformatf("to_hold%0d", c), arb_if.grant, 4'b0010);
         check($sformatf("to_terr%0d", c), arb_if.timeout_err, 1'b0);
         tick();
      end
`ifdef ARB_TIMEOUT_EN
      check("to_rel", arb_if.grant, 4'b0000);
      check("to_pulse", arb_if.timeout_err, 1'b1);
`else
      check("nto_hold", arb_if.grant, 4'b0010);
      check("nto_terr", arb_if.timeout_err, 1'b0);
      arb_if.done = 1'b1;
      tick();
      check("nto_rel", arb_if.grant, 4'b0000);
      arb_if.done = 1'b0;
`endif
      arb_if.req = 4'b0110;
      tick();
      check("to_ptr2", arb_if.grant, 4'b0100);
      check("to_terr_end", arb_if.timeout_err, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
